// File: rtl/tx_arbiter_if.sv
// Request, TX and RX-reply signals of the tx_arbiter.
// The arbiter connects through the slave modport; requesters/TX/RX drive the master side.
interface tx_arbiter_if #(
  parameter int NCH      = 2,
  parameter int CMD_BITS = 2,
  parameter int DEPTH    = 2
) ();
  logic [NCH-1:0]          req_valid;
  logic [NCH*CMD_BITS-1:0] req_cmd;
  logic [NCH-1:0]          req_reply_wanted;
  logic [NCH-1:0]          req_reserve;
  logic [NCH-1:0]          req_started;
  logic                    tx_command_valid;
  logic [CMD_BITS-1:0]     tx_command;
  logic                    tx_command_started;
  logic                    tx_done;
  logic                    rx_done;
  logic [NCH-1:0]          rx_owner;
  logic [$clog2(DEPTH):0]  outstanding;
  logic                    rx_unexpected;

  modport master (
    output req_valid, req_cmd, req_reply_wanted, req_reserve,
           tx_command_started, tx_done, rx_done,
    input  req_started, tx_command_valid, tx_command,
           rx_owner, outstanding, rx_unexpected
  );

  modport slave (
    input  req_valid, req_cmd, req_reply_wanted, req_reserve,
           tx_command_started, tx_done, rx_done,
    output req_started, tx_command_valid, tx_command,
           rx_owner, outstanding, rx_unexpected
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: grants one channel at a time to the TX serialiser and tracks reply owners.
// Define TX_ARBITER_RR_EN for round-robin selection; otherwise fixed priority, lowest index wins.
module tx_arbiter #(
  parameter int NCH      = 2,
  parameter int CMD_BITS = 2,
  parameter int DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  tx_arbiter_if.slave bus
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;
  state_t state, state_nx;

  logic [IDW-1:0]      grant;
  logic [NCH-1:0]      grant_oh;
  logic [CMD_BITS-1:0] grant_cmd;
  logic                grant_reply;
  logic                started;

  logic [NCH-1:0]      eligible;
  logic                res_any;
  logic [IDW-1:0]      res_id;
  logic [NCH-1:0]      search_vec;
  logic [IDW-1:0]      offset;
  logic                any_eligible;
  logic [IDW-1:0]      pick;
  logic [CMD_BITS-1:0] pick_cmd;
  logic                pick_reply;

  logic [IDW-1:0]      mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                push, pop;
  logic                unexpected;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    res_any  = 1'b0;
    res_id   = '0;
    eligible = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.req_reserve[k]) begin
        res_any = 1'b1;
        res_id  = IDW'(k);
      end
    end
    // A reply-wanted command needs a free FIFO slot now; a same-cycle pop does not help.
    for (int k = 0; k < NCH; k++) begin
      eligible[k] = bus.req_valid[k]
                 && (!res_any || res_id == IDW'(k))
                 && (!bus.req_reply_wanted[k] || count < CW'(DEPTH));
    end
  end

`ifdef TX_ARBITER_RR_EN
  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   rr_sum;

  always_ff @(posedge clk) begin
    if (reset)        rr_ptr <= '0;
    else if (started) rr_ptr <= (grant == IDW'(NCH - 1)) ? '0 : grant + 1'b1;
  end

  // Rotate so rr_ptr becomes bit 0, pick lowest, then rotate the index back.
  assign search_vec = NCH'({eligible, eligible} >> rr_ptr);
  assign rr_sum     = {1'b0, offset} + {1'b0, rr_ptr};
  assign pick       = (rr_sum >= (IDW+1)'(NCH)) ? IDW'(rr_sum - (IDW+1)'(NCH)) : IDW'(rr_sum);
`else
  assign search_vec = eligible;
  assign pick       = offset;
`endif

  always_comb begin
    offset       = '0;
    any_eligible = |search_vec;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (search_vec[k]) offset = IDW'(k);
    end
  end

  always_comb begin
    pick_cmd   = '0;
    pick_reply = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (pick == IDW'(k)) begin
        pick_cmd   = bus.req_cmd[k*CMD_BITS +: CMD_BITS];
        pick_reply = bus.req_reply_wanted[k];
      end
    end
  end

  assign grant_oh = NCH'(1) << grant;
  assign started  = (state == OFFER) && bus.tx_command_started;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (any_eligible) state_nx = OFFER;
      OFFER: begin
        if (bus.tx_command_started)             state_nx = bus.tx_done ? IDLE : BUSY;
        else if (!(|(bus.req_valid & grant_oh))) state_nx = IDLE;
      end
      BUSY:  if (bus.tx_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_command_valid = (state == OFFER);
    bus.tx_command       = grant_cmd;
    bus.req_started      = started ? grant_oh : '0;
  end

  // The grant is frozen from selection until the FSM leaves OFFER.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      grant_cmd   <= '0;
      grant_reply <= 1'b0;
    end else if (state == IDLE && any_eligible) begin
      grant       <= pick;
      grant_cmd   <= pick_cmd;
      grant_reply <= pick_reply;
    end
  end

  assign push = started && grant_reply && (count < CW'(DEPTH) || bus.rx_done);
  assign pop  = bus.rx_done && (count != '0 || push);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      unexpected <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.rx_done && !pop) unexpected <= 1'b1;
    end
  end

  // NOTE: the id storage has no reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant;
  end

  assign bus.rx_owner      = (count != '0) ? (NCH'(1) << mem[rd_ptr]) : '0;
  assign bus.outstanding   = count;
  assign bus.rx_unexpected = unexpected;
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Multi-channel TX command arbiter with reply tracking. It sits between the instruction scheduler, the prefetcher and any further requesters, and the single TX serialiser. It grants one command at a time and honours bus reservations. It records which channel owns each outstanding read so incoming RX replies can be routed, with up to DEPTH reads in flight instead of one.

## Interface
Parameters:
- NCH, 2: number of requesting channels (≥2); channel 0 is highest priority at reset.
- CMD_BITS, 2: width of a TX command header code.
- DEPTH, 2: maximum outstanding reply-wanted commands (power of 2, ≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel command request; held until the matching req_started bit pulses.
- req_cmd  in  NCH*CMD_BITS  per-channel header; channel k uses bits [k*CMD_BITS +: CMD_BITS].
- req_reply_wanted  in  NCH  command expects an RX reply.
- req_reserve  in  NCH  channel claims exclusive TX access.
- req_started  out  NCH  one-hot pulse: the channel's command was accepted by TX.
- tx_command_valid  out  1  a command is offered to TX.
- tx_command  out  CMD_BITS  offered header.
- tx_command_started  in  1  TX accepted the offered command this cycle.
- tx_done  in  1  TX finished the current message.
- rx_done  in  1  reply message fully received.
- rx_owner  out  NCH  one-hot owner of the oldest outstanding reply; 0 when none.
- outstanding  out  $clog2(DEPTH)+1  number of replies in flight.
- rx_unexpected  out  1  sticky: rx_done arrived with nothing outstanding.

## Operation
- FSM states:
  - IDLE: compute the eligible set and select; if any channel is eligible, latch grant id, header and reply flag, then go to OFFER.
  - OFFER: tx_command_valid=1 with the latched tx_command. On tx_command_started, pulse req_started[grant] and go to BUSY. If req_valid[grant] drops without a start, return to IDLE with no pulse.
  - BUSY: wait for tx_done, then go to IDLE. If tx_done coincides with the start, go straight to IDLE.
- Eligibility of channel k:
  - req_valid[k] is high.
  - No other channel holds req_reserve; if several reserve, only the lowest-index reserver is unlocked.
  - If req_reply_wanted[k], then outstanding < DEPTH at selection time. A same-cycle rx_done does not count.
- Selection: round-robin or fixed priority (see Configuration). The latched grant does not change while in OFFER, even if higher-priority requests arrive.
- Reply FIFO (DEPTH entries of $clog2(NCH)-bit ids, wrapping read/write pointers):
  - Push the grant id on tx_command_started when the latched reply flag is set.
  - Pop on rx_done.
  - Push and pop in the same cycle: both happen, count unchanged. This is also legal when full and when empty+push.
  - Pop when empty: ignored; set rx_unexpected.
  - rx_owner is the decoded head id while outstanding≠0.

## Timing
- Reset values: tx_command_valid=0, tx_command=0, req_started=0, rx_owner=0, outstanding=0, rx_unexpected=0. FSM in IDLE, pointers 0, round-robin pointer set so channel 0 is searched first.
- Request-to-offer latency: req_valid seen in IDLE at cycle n gives tx_command_valid=1 at n+1.
- req_started: single-cycle pulse, same cycle as tx_command_started. Push is visible in outstanding at the next cycle.
- rx_owner updates the cycle after a pop or a push-into-empty.
- Minimum spacing between two grants: 1 IDLE cycle after BUSY exits.
- Reset mid-operation: all state returns to reset values on the next edge. Outstanding replies are forgotten.

## Configuration
- TX_ARBITER_RR_EN defined: round-robin selection. After a start on channel k, the search begins at (k+1) mod NCH.
- Not defined: fixed priority, lowest index wins. The round-robin pointer logic is removed.
- Reservation lock applies in both modes.

## Test plan
- Single request: ch1 req_valid, cmd=2'b01, reply wanted; TX starts 3 cycles later -> tx_command=01 from cycle 1; req_started=2'b10 at start; outstanding=1; rx_owner=2'b10; rx_done -> outstanding=0, rx_owner=0.
- Contention, RR_EN, NCH=3: all channels hold req_valid continuously -> start order 0,1,2,0. Without the macro -> 0,0,0.
- Reservation: ch1 holds req_reserve, ch0 and ch1 both request -> only ch1 granted until req_reserve drops; then ch0 is granted.
- FIFO full, DEPTH=2: two reply-wanted starts and no rx_done -> a third reply-wanted request is not offered. A non-reply request from another channel is offered. One rx_done -> the third request is offered next IDLE cycle.
- Simultaneous push and pop at outstanding=1 -> stays 1, and rx_owner moves to the new id. rx_done at outstanding=0 -> rx_unexpected=1, held until reset.
- Withdraw and reset: req_valid drops in OFFER -> back to IDLE with no req_started. Reset asserted in BUSY with outstanding=2 -> all outputs 0 next cycle.
